// File: rtl/little_digit_scanner.sv
// Text-window scanner: maps VGA coordinates to {char code, glyph column, glyph row} for the font ROM
// address map, then turns the returned ROM bit into an RGB pixel with sync/DE delayed to match.
module little_digit_scanner #(
    parameter int          TEXT_X0 = 16,
    parameter int          TEXT_Y0 = 32,
    parameter int          COLS    = 16,
    parameter int          LINES   = 4,
    parameter int          V_SCALE = 4,
    parameter logic [11:0] FG_RGB  = 12'hFFF,
    parameter logic [11:0] BG_RGB  = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [7:0]  data,
    output logic [10:0] col_all,
    output logic [2:0]  row_all,
    input  logic        rom_bit,
    output logic [11:0] rgb,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out
);

    localparam int DEPTH  = COLS * LINES;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CELL_H = 2 * V_SCALE;

    localparam logic [10:0] X_LO     = 11'(TEXT_X0);
    localparam logic [10:0] X_HI     = 11'(TEXT_X0 + 8 * COLS);
    localparam logic [10:0] Y_LO     = 11'(TEXT_Y0);
    localparam logic [10:0] Y_HI     = 11'(TEXT_Y0 + CELL_H * LINES);
    localparam logic [10:0] CELL_H_W = 11'(CELL_H);
    localparam logic [10:0] VSCALE_W = 11'(V_SCALE);
    localparam logic [10:0] COLS_W   = 11'(COLS);
    localparam logic [8:0]  DEPTH_W  = 9'(DEPTH);

    logic [7:0]  text_q [DEPTH];

    logic [7:0]  data_q, data_d;
    logic [10:0] col_q, col_d;
    logic        row_q, row_d;
    logic        win1_q, de1_q, hs1_q, vs1_q;
    logic [11:0] rgb_q, rgb_d;
    logic        de2_q, hs2_q, vs2_q;

    logic        in_win;
    logic        wr_ok;
    logic [10:0] dx, dy, line_idx, idx;
    logic        glyph_row;
    logic        unused_bits;

    // Window test is done on the raw coordinates, so anything left of / above the
    // window fails the lower-bound compare and never wraps into the buffer.
    always_comb begin
        in_win    = de_in && (hcount >= X_LO) && (hcount < X_HI)
                          && (vcount >= Y_LO) && (vcount < Y_HI);
        dx        = hcount - X_LO;
        dy        = vcount - Y_LO;
        line_idx  = dy / CELL_H_W;
        glyph_row = (dy % CELL_H_W) >= VSCALE_W;
        idx       = line_idx * COLS_W + (dx >> 3);
        wr_ok     = {1'b0, wr_addr} < DEPTH_W;

        data_d = 8'h20;
        col_d  = '0;
        row_d  = 1'b0;
        if (in_win) begin
            data_d = text_q[idx[IDX_W-1:0]];
            col_d  = dx;
            row_d  = glyph_row;
        end

        rgb_d = (win1_q && de1_q && rom_bit) ? FG_RGB : BG_RGB;
    end

    assign unused_bits = ^{idx[10:IDX_W]};

    // Buffer read in stage 1 sees the pre-edge contents, giving read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) text_q[i] <= 8'h20;
            data_q <= '0;
            col_q  <= '0;
            row_q  <= 1'b0;
            win1_q <= 1'b0;
            de1_q  <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            rgb_q  <= BG_RGB;
            de2_q  <= 1'b0;
            hs2_q  <= 1'b0;
            vs2_q  <= 1'b0;
        end else begin
            if (wr_en && wr_ok) text_q[wr_addr[IDX_W-1:0]] <= wr_data;
            data_q <= data_d;
            col_q  <= col_d;
            row_q  <= row_d;
            win1_q <= in_win;
            de1_q  <= de_in;
            hs1_q  <= hs_in;
            vs1_q  <= vs_in;
            rgb_q  <= rgb_d;
            de2_q  <= de1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
        end
    end

    assign data    = data_q;
    assign col_all = col_q;
    assign row_all = {2'b00, row_q};
    assign rgb     = rgb_q;
    assign de_out  = de2_q;
    assign hs_out  = hs2_q;
    assign vs_out  = vs2_q;

endmodule

// File: tb/tb_little_digit_scanner.sv
// Directed bench for little_digit_scanner: text buffer reads, window edges, pipeline
// alignment of rgb/sync and reset behaviour, with hand-computed expectations.
module tb_little_digit_scanner;

    logic        clk;
    logic        rst;
    logic [10:0] hcount, vcount;
    logic        de_in, hs_in, vs_in;
    logic        wr_en;
    logic [7:0]  wr_addr, wr_data;
    logic [7:0]  data;
    logic [10:0] col_all;
    logic [2:0]  row_all;
    logic        rom_bit;
    logic [11:0] rgb;
    logic        de_out, hs_out, vs_out;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    little_digit_scanner dut (
        .clk     (clk),
        .rst     (rst),
        .hcount  (hcount),
        .vcount  (vcount),
        .de_in   (de_in),
        .hs_in   (hs_in),
        .vs_in   (vs_in),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (data),
        .col_all (col_all),
        .row_all (row_all),
        .rom_bit (rom_bit),
        .rgb     (rgb),
        .de_out  (de_out),
        .hs_out  (hs_out),
        .vs_out  (vs_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int h, input int v, input logic de);
        hcount = 11'(h);
        vcount = 11'(v);
        de_in  = de;
    endtask

    task automatic write_char(input int addr, input logic [7:0] ch);
        wr_en   = 1'b1;
        wr_addr = 8'(addr);
        wr_data = ch;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            pass_cnt++;
    endtask

    logic hs_pat [10];
    logic vs_pat [10];

    initial begin
        rst = 1'b1; hcount = '0; vcount = '0; de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rom_bit = 1'b0;

        // reset values, with busy inputs presented during reset
        drive(16, 32, 1'b1); hs_in = 1'b1; vs_in = 1'b1; rom_bit = 1'b1;
        tick(); tick();
        check_eq("rst_data", 32'(data), 32'h0);
        check_eq("rst_col", 32'(col_all), 32'h0);
        check_eq("rst_row", 32'(row_all), 32'h0);
        check_eq("rst_rgb", 32'(rgb), 32'h000);
        check_eq("rst_de", 32'(de_out), 32'h0);
        check_eq("rst_hs", 32'(hs_out), 32'h0);
        check_eq("rst_vs", 32'(vs_out), 32'h0);
        rst = 1'b0; hs_in = 1'b0; vs_in = 1'b0; rom_bit = 1'b0;

        // full scan of window plus margin, empty buffer
        for (int v = 30; v < 66; v++) begin
            for (int h = 10; h < 150; h++) begin
                bit inw;
                drive(h, v, 1'b1);
                tick();
                inw = (h >= 16) && (h < 144) && (v >= 32) && (v < 64);
                check_eq("scan_data", 32'(data), 32'h20);
                check_eq("scan_col", 32'(col_all), inw ? 32'(h - 16) : 32'h0);
                check_eq("scan_row", 32'(row_all), inw ? 32'(((v - 32) % 8) >= 4) : 32'h0);
                check_eq("scan_rgb", 32'(rgb), 32'h000);
            end
        end

        drive(0, 0, 1'b0);
        write_char(0, 8'h35);
        write_char(1, 8'h42);
        write_char(37, 8'h5A);
        write_char(63, 8'h7E);

        // first cell, then rom bit returned one clk later
        drive(16, 32, 1'b1); tick();
        check_eq("c0_data", 32'(data), 32'h35);
        check_eq("c0_col", 32'(col_all), 32'h0);
        check_eq("c0_row", 32'(row_all), 32'h0);
        rom_bit = 1'b1; drive(0, 0, 1'b0); tick();
        check_eq("c0_rgb", 32'(rgb), 32'hFFF);
        check_eq("c0_de", 32'(de_out), 32'h1);
        rom_bit = 1'b0;

        drive(23, 36, 1'b1); tick();
        check_eq("c0_col7", 32'(col_all), 32'h7);
        check_eq("c0_row1", 32'(row_all), 32'h1);
        check_eq("c0_data7", 32'(data), 32'h35);
        drive(24, 36, 1'b1); tick();
        check_eq("c1_col", 32'(col_all), 32'h8);
        check_eq("c1_data", 32'(data), 32'h42);
        drive(56, 53, 1'b1); tick();
        check_eq("c37_data", 32'(data), 32'h5A);
        check_eq("c37_col", 32'(col_all), 32'd40);
        check_eq("c37_row", 32'(row_all), 32'h1);
        drive(143, 63, 1'b1); tick();
        check_eq("c63_data", 32'(data), 32'h7E);
        check_eq("c63_col", 32'(col_all), 32'd127);
        check_eq("c63_row", 32'(row_all), 32'h1);

        // window edges, rgb stays background even with rom_bit high
        drive(144, 32, 1'b1); tick();
        check_eq("x144_data", 32'(data), 32'h20);
        check_eq("x144_col", 32'(col_all), 32'h0);
        rom_bit = 1'b1;
        drive(15, 32, 1'b1); tick();
        check_eq("x144_rgb", 32'(rgb), 32'h000);
        check_eq("x15_data", 32'(data), 32'h20);
        check_eq("x15_col", 32'(col_all), 32'h0);
        drive(16, 64, 1'b1); tick();
        check_eq("x15_rgb", 32'(rgb), 32'h000);
        check_eq("y64_data", 32'(data), 32'h20);
        drive(16, 31, 1'b1); tick();
        check_eq("y64_rgb", 32'(rgb), 32'h000);
        check_eq("y31_data", 32'(data), 32'h20);
        drive(16, 32, 1'b0); tick();
        check_eq("de0_data", 32'(data), 32'h20);
        drive(0, 0, 1'b0); tick();
        check_eq("de0_rgb", 32'(rgb), 32'h000);
        check_eq("de0_deout", 32'(de_out), 32'h0);
        rom_bit = 1'b0;

        // read-before-write on index 3, then out-of-range write
        drive(40, 32, 1'b1);
        wr_en = 1'b1; wr_addr = 8'd3; wr_data = 8'h41;
        tick();
        wr_en = 1'b0;
        check_eq("rbw_old", 32'(data), 32'h20);
        tick();
        check_eq("rbw_new", 32'(data), 32'h41);
        write_char(64, 8'h99);
        write_char(127, 8'h98);
        drive(16, 32, 1'b1); tick();
        check_eq("oor_idx0", 32'(data), 32'h35);
        drive(143, 63, 1'b1); tick();
        check_eq("oor_idx63", 32'(data), 32'h7E);

        // hs/vs patterns emerge one edge after stage 1, i.e. 2 clk after being sampled
        hs_pat = '{1, 0, 1, 1, 0, 0, 1, 0, 0, 0};
        vs_pat = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 0};
        drive(0, 0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            hs_in = hs_pat[k];
            vs_in = vs_pat[k];
            tick();
            if (k > 0) begin
                check_eq("hs_delay", 32'(hs_out), 32'(hs_pat[k-1]));
                check_eq("vs_delay", 32'(vs_out), 32'(vs_pat[k-1]));
            end
        end

        // reset mid-line
        drive(16, 32, 1'b1); hs_in = 1'b1; vs_in = 1'b1; rom_bit = 1'b1;
        tick(); tick();
        rst = 1'b1; tick();
        check_eq("mid_data", 32'(data), 32'h0);
        check_eq("mid_col", 32'(col_all), 32'h0);
        check_eq("mid_row", 32'(row_all), 32'h0);
        check_eq("mid_rgb", 32'(rgb), 32'h000);
        check_eq("mid_de", 32'(de_out), 32'h0);
        check_eq("mid_hs", 32'(hs_out), 32'h0);
        check_eq("mid_vs", 32'(vs_out), 32'h0);
        rst = 1'b0; hs_in = 1'b0; vs_in = 1'b0; rom_bit = 1'b0;
        drive(16, 32, 1'b1); tick();
        check_eq("post_idx0", 32'(data), 32'h20);
        drive(143, 63, 1'b1); tick();
        check_eq("post_idx63", 32'(data), 32'h20);
        drive(40, 32, 1'b1); tick();
        check_eq("post_idx3", 32'(data), 32'h20);
        check_eq("post_de", 32'(de_out), 32'h1);

        // final report
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
